// File: rtl/alaghi_adder.sv
// Toggle-flip-flop scaled adder: out carries (P(x)+P(y))/2 for unipolar streams.
// Mismatching input bits are passed alternately as 1 and 0; agreeing bits pass through.
module alaghi_adder (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  output logic out
);

  logic r_t;
  logic w_mismatch;

  assign w_mismatch = x ^ y;

  // Toggle state flips only on mismatch cycles; reset parks it at 1 so the first mismatch emits a 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t <= 1'b1;
    end else begin
      r_t <= r_t ^ w_mismatch;
    end
  end

  assign out = rst ? 1'b0 : ((x & y) | (w_mismatch & r_t));

endmodule

// File: tb/tb_alaghi_adder.sv
// Self-checking bench for alaghi_adder: a mismatch-parity model checked every cycle
// plus directed vectors with literal expectations.
module tb_alaghi_adder;

  logic clk = 1'b0;
  logic rst;
  logic x;
  logic y;
  logic out;

  int checks = 0;
  int errors = 0;

  // Model state: mismatches seen since the last reset edge; valid once a reset edge occurred.
  int  mm_cnt = 0;
  bit  model_valid = 1'b0;
  logic model_out;

  alaghi_adder dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y),
    .out (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mm_cnt = 0;
      model_valid = 1'b1;
    end else if (x != y) begin
      mm_cnt = mm_cnt + 1;
    end
  end

  // Even number of prior mismatches -> this mismatch emits 1, odd -> 0.
  always @* begin
    if (rst)         model_out = 1'b0;
    else if (x == y) model_out = x;
    else             model_out = ((mm_cnt % 2) == 0) ? 1'b1 : 1'b0;
  end

  always @(negedge clk) begin
    if (model_valid || rst) begin
      checks = checks + 1;
      if (out !== model_out) begin
        errors = errors + 1;
        $display("FAIL model t=%0t rst=%b x=%b y=%b out=%b expected=%b", $time, rst, x, y, out, model_out);
      end
    end
  end

  int ones;

  // Drive one cycle just after a rising edge and check a hand-computed value.
  task automatic cyc(input logic r, input logic xi, input logic yi,
                     input logic exp_out, input string name);
    @(posedge clk);
    #1;
    rst = r;
    x   = xi;
    y   = yi;
    #3;
    checks = checks + 1;
    if (out !== exp_out) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t out=%b expected=%b", name, $time, out, exp_out);
    end
    if (out === 1'b1) ones = ones + 1;
  endtask

  task automatic check_ones(input int want, input string name);
    checks = checks + 1;
    if (ones != want) begin
      errors = errors + 1;
      $display("FAIL %s ones=%0d expected=%0d", name, ones, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    x   = 1'b0;
    y   = 1'b0;
    ones = 0;

    // Reset held 4 cycles; mismatch during reset still yields 0.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset_hold");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "reset_wins");

    // Agreement then first mismatches.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "agree_00");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, "agree_11");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "first_mismatch");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "second_mismatch");

    // Alternation from reset: 1,0,1,0,1,0.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset_alt");
    ones = 0;
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b1, 1'b0, ((i % 2) == 0) ? 1'b1 : 1'b0, "alternation");
    check_ones(3, "alternation_count");

    // Mixed statistics: x all 1, y 1 then 0 for 8 cycles each -> 12 ones.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset_stat_a");
    ones = 0;
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b1, (i < 8) ? 1'b1 : 1'b0, (i < 8) ? 1'b1 : (((i % 2) == 0) ? 1'b1 : 1'b0), "stat_xy");
    check_ones(12, "stat_xy_count");

    cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset_stat_b");
    ones = 0;
    for (int i = 0; i < 16; i++)
      cyc(1'b0, (i < 8) ? 1'b1 : 1'b0, 1'b1, (i < 8) ? 1'b1 : (((i % 2) == 0) ? 1'b1 : 1'b0), "stat_yx");
    check_ones(12, "stat_yx_count");

    // Mid-stream reset after an odd number of mismatches restores t=1.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset_mid_a");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "mid_odd_mismatch");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "mid_reset");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, "mid_after_reset");

    // Pseudo-random tail checked only by the model process.
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
      x   = 1'($urandom_range(0, 1));
      y   = 1'($urandom_range(0, 1));
    end

    @(posedge clk);
    #6;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
